// File: rtl/hazard_controller_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding select
// encodings, register-index width and the load-use stall FSM state type.
package hazard_controller_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned STALL_CNT_W = 3;

  // ALU operand source selects
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN       = 1'b0,
    LOADSTALL = 1'b1
  } hazardState_t;

endpackage

// File: rtl/hazard_controller_fwd.sv
// Forwarding unit for one ALU operand (combinational).
// Ports:
//   exRs        - source register of the EX instruction for this operand
//   memRd/wbRd  - destinations in MEM / WB
//   memRegWrite/wbRegWrite - MEM / WB write the register file
//   forward     - operand source: FWD_REG, FWD_WB or FWD_MEM
module hazard_controller_fwd
  import hazard_controller_pkg::*;
(
  input  logic [REG_W-1:0] exRs,
  input  logic [REG_W-1:0] memRd,
  input  logic [REG_W-1:0] wbRd,
  input  logic             memRegWrite,
  input  logic             wbRegWrite,
  output logic [1:0]       forward
);

  // MEM holds the younger result so it wins over WB; x0 is never forwarded.
  always_comb begin
    forward = FWD_REG;
    if (memRegWrite && (memRd != '0) && (memRd == exRs)) begin
      forward = FWD_MEM;
    end else if (wbRegWrite && (wbRd != '0) && (wbRd == exRs)) begin
      forward = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the 5-stage core. Selects ALU operand
// forwarding, stalls on load-use and data-memory wait, flushes the front end
// on a taken branch or jump, and keeps saturating stall/flush counters.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   idRs1/idRs2, idUsesRs1/2   - ID instruction sources and their use flags
//   exValid, exRs1/exRs2, exRd - EX instruction validity, sources, destination
//   exMemRead, exIsBranch, exIsJump, exBranch - EX load / branch / jump info
//   memRd/wbRd, memRegWrite/wbRegWrite - MEM/WB register writes
//   memBusy                    - data memory not ready
//   forwardA/forwardB          - ALU in1/in2 source select
//   stallIf/Id/Ex/Mem, bubbleEx, flushIf, flushId, pcRedirect - pipeline control
//   stallCycles, flushCount    - saturating performance counters
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned LOAD_USE_STALLS = 1,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_W-1:0]     idRs1,
  input  logic [REG_W-1:0]     idRs2,
  input  logic                 idUsesRs1,
  input  logic                 idUsesRs2,
  input  logic                 exValid,
  input  logic [REG_W-1:0]     exRs1,
  input  logic [REG_W-1:0]     exRs2,
  input  logic [REG_W-1:0]     exRd,
  input  logic                 exMemRead,
  input  logic                 exIsBranch,
  input  logic                 exIsJump,
  input  logic                 exBranch,
  input  logic [REG_W-1:0]     memRd,
  input  logic [REG_W-1:0]     wbRd,
  input  logic                 memRegWrite,
  input  logic                 wbRegWrite,
  input  logic                 memBusy,
  output logic [1:0]           forwardA,
  output logic [1:0]           forwardB,
  output logic                 stallIf,
  output logic                 stallId,
  output logic                 stallEx,
  output logic                 stallMem,
  output logic                 bubbleEx,
  output logic                 flushIf,
  output logic                 flushId,
  output logic                 pcRedirect,
  output logic [CNT_WIDTH-1:0] stallCycles,
  output logic [CNT_WIDTH-1:0] flushCount
);

  // The first stall cycle is spent in RUN, so LOADSTALL covers the remaining ones.
  localparam logic             MULTI_STALL = (LOAD_USE_STALLS > 1);
  localparam logic [STALL_CNT_W-1:0] STALL_INIT =
    MULTI_STALL ? STALL_CNT_W'(LOAD_USE_STALLS - 2) : '0;

  hazardState_t            state, stateNext;
  logic [STALL_CNT_W-1:0]  stallCnt, stallCntNext;
  logic                    loadUse, redirect;
  logic [1:0]              fwdA, fwdB;

  hazard_controller_fwd u_fwd_in1 (
    .exRs        (exRs1),
    .memRd       (memRd),
    .wbRd        (wbRd),
    .memRegWrite (memRegWrite),
    .wbRegWrite  (wbRegWrite),
    .forward     (fwdA)
  );

  hazard_controller_fwd u_fwd_in2 (
    .exRs        (exRs2),
    .memRd       (memRd),
    .wbRd        (wbRd),
    .memRegWrite (memRegWrite),
    .wbRegWrite  (wbRegWrite),
    .forward     (fwdB)
  );

  assign forwardA = reset ? FWD_REG : fwdA;
  assign forwardB = reset ? FWD_REG : fwdB;

  // Hazard detection
  assign loadUse = exValid && exMemRead && (exRd != '0) &&
                   ((idUsesRs1 && (idRs1 == exRd)) || (idUsesRs2 && (idRs2 == exRd)));
  assign redirect = exValid && ((exIsBranch && exBranch) || exIsJump);

  // Next state and control outputs; priority memBusy > redirect > loadUse
  always_comb begin
    stateNext    = state;
    stallCntNext = stallCnt;
    stallIf      = 1'b0;
    stallId      = 1'b0;
    stallEx      = 1'b0;
    stallMem     = 1'b0;
    bubbleEx     = 1'b0;
    flushIf      = 1'b0;
    flushId      = 1'b0;
    pcRedirect   = 1'b0;

    if (reset) begin
      stateNext    = RUN;
      stallCntNext = '0;
    end else if (memBusy) begin
      // Whole pipe frozen; FSM holds so a load-use stall resumes afterwards.
      stallIf  = 1'b1;
      stallId  = 1'b1;
      stallEx  = 1'b1;
      stallMem = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            // ID is on the wrong path, so any load-use there is moot.
            pcRedirect = 1'b1;
            flushIf    = 1'b1;
            flushId    = 1'b1;
          end else if (loadUse) begin
            stallIf  = 1'b1;
            stallId  = 1'b1;
            bubbleEx = 1'b1;
            if (MULTI_STALL) begin
              stateNext    = LOADSTALL;
              stallCntNext = STALL_INIT;
            end
          end
        end
        LOADSTALL: begin
          // EX holds a bubble here, so redirect/loadUse inputs are ignored.
          stallIf  = 1'b1;
          stallId  = 1'b1;
          bubbleEx = 1'b1;
          if (stallCnt == '0) begin
            stateNext = RUN;
          end else begin
            stallCntNext = stallCnt - STALL_CNT_W'(1);
          end
        end
        default: begin
          stateNext    = RUN;
          stallCntNext = '0;
        end
      endcase
    end
  end

  // State, stall counter and saturating performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      stallCnt    <= '0;
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      state    <= stateNext;
      stallCnt <= stallCntNext;
      if (stallId && (stallCycles != '1)) begin
        stallCycles <= stallCycles + CNT_WIDTH'(1);
      end
      if (pcRedirect && (flushCount != '1)) begin
        flushCount <= flushCount + CNT_WIDTH'(1);
      end
    end
  end

endmodule
